// File: rtl/qspi_tx_if.sv
// Handshake/bus bundle between the QSPI TX shifter, its TX FIFO, the pad drivers
// and the controller that issues transfers.
interface qspi_tx_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) ();
    logic                  start;
    logic                  abort;
    logic [1:0]            mode;
    logic [CNT_WIDTH-1:0]  byte_count;
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic [3:0]            io_out;
    logic [3:0]            io_oe;
    logic                  sclk_en;
    logic                  busy;
    logic                  done;
    logic                  underrun;

    modport slave (
        input  start, abort, mode, byte_count, fifo_empty, fifo_rd_data,
        output fifo_rd_en, io_out, io_oe, sclk_en, busy, done, underrun
    );

    modport master (
        output start, abort, mode, byte_count, fifo_empty, fifo_rd_data,
        input  fifo_rd_en, io_out, io_oe, sclk_en, busy, done, underrun
    );
endinterface

// File: rtl/qspi_tx_shifter.sv
// QSPI transmit serializer: pops 32-bit words from the TX FIFO and shifts them
// MSB first onto 1, 2 or 4 IO lanes, gating sclk to cycles carrying new data.
module qspi_tx_shifter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic       clk,
    input  logic       rst_n,   // active-high synchronous reset despite the name
    qspi_tx_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, SHIFT, DONE} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic [CNT_WIDTH-1:0]  left_q, left_d;
    logic [5:0]            word_cnt_q, word_cnt_d;
    logic [3:0]            byte_cnt_q, byte_cnt_d;
    logic [1:0]            mode_q, mode_d;
    logic                  underrun_q, underrun_d;

    logic [3:0] cpb;        // shift cycles per byte
    logic [1:0] cpb_log2;
    logic [3:0] oe_mask;
    logic [2:0] nb;         // bytes carried by the word being loaded

    // Lane decode; mode 11 falls through to single.
    always_comb begin
        cpb      = 4'd8;
        cpb_log2 = 2'd3;
        oe_mask  = 4'b0001;
        case (mode_q)
            2'b01: begin cpb = 4'd4; cpb_log2 = 2'd2; oe_mask = 4'b0011; end
            2'b10: begin cpb = 4'd2; cpb_log2 = 2'd1; oe_mask = 4'b1111; end
            default: ;
        endcase
    end

    assign nb = (left_q >= CNT_WIDTH'(4)) ? 3'd4 : left_q[2:0];

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        left_d     = left_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        mode_d     = mode_q;
        underrun_d = underrun_q;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        mode_d     = bus.mode;
                        left_d     = bus.byte_count;
                        underrun_d = 1'b0;
                        state_d    = (bus.byte_count != '0) ? FETCH : DONE;
                    end
                end
                FETCH: begin
                    if (!bus.fifo_empty) state_d = WAIT;
                    else                 underrun_d = 1'b1;
                end
                WAIT: begin
                    sr_d       = bus.fifo_rd_data;
                    word_cnt_d = 6'(nb) << cpb_log2;
                    byte_cnt_d = cpb;
                    state_d    = SHIFT;
                end
                SHIFT: begin
                    case (mode_q)
                        2'b01:   sr_d = sr_q << 2;
                        2'b10:   sr_d = sr_q << 4;
                        default: sr_d = sr_q << 1;
                    endcase
                    word_cnt_d = word_cnt_q - 6'd1;
                    if (byte_cnt_q == 4'd1) begin
                        byte_cnt_d = cpb;
                        left_d     = (left_q != '0) ? left_q - 1'b1 : '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q - 4'd1;
                    end
                    // Partial last word: stopping here discards its low bytes.
                    if (word_cnt_q == 6'd1)
                        state_d = (left_d != '0) ? FETCH : DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            left_q     <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            mode_q     <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            left_q     <= left_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            mode_q     <= mode_d;
            underrun_q <= underrun_d;
        end
    end

    always_comb begin
        bus.fifo_rd_en = (state_q == FETCH) && !bus.fifo_empty;
        bus.io_out     = 4'b0000;
        bus.io_oe      = 4'b0000;
        bus.sclk_en    = 1'b0;
        if (state_q == SHIFT) begin
            bus.sclk_en = 1'b1;
            bus.io_oe   = oe_mask;
            case (mode_q)
                2'b01:   bus.io_out = {2'b00, sr_q[DATA_WIDTH-1 -: 2]};
                2'b10:   bus.io_out = sr_q[DATA_WIDTH-1 -: 4];
                default: bus.io_out = {3'b000, sr_q[DATA_WIDTH-1]};
            endcase
        end
        bus.busy     = (state_q != IDLE);
        bus.done     = (state_q == DONE);
        bus.underrun = underrun_q;
    end
endmodule

// File: tb/tb_qspi_tx_shifter.sv
// Directed bench for qspi_tx_shifter: a scoreboard queue of expected lane beats
// is drained by a monitor on every sclk_en cycle; cycle-exact checks sit inline.
module tb_qspi_tx_shifter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    qspi_tx_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) bus ();

    qspi_tx_shifter #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int k     = 0;

    // Registered-read FIFO model
    logic [31:0] mem [0:15];
    int wp = 0;
    int rp = 0;
    int pops = 0;
    assign bus.fifo_empty = (wp == rp);
    always @(posedge clk) begin
        if (bus.fifo_rd_en && (wp != rp)) begin
            bus.fifo_rd_data <= mem[rp % 16];
            rp   <= rp + 1;
            pops <= pops + 1;
        end
    end

    // Scoreboard: {io_oe, io_out} per expected SHIFT beat
    logic [7:0] exp_q [$];
    logic [7:0] mon_e;
    always @(negedge clk) begin
        if (bus.sclk_en) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL beat: unexpected beat oe/out=%h, none expected", {bus.io_oe, bus.io_out});
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.io_oe, bus.io_out} !== mon_e) begin
                    bad++;
                    $display("FAIL beat: got oe/out=%h want %h", {bus.io_oe, bus.io_out}, mon_e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        mem[wp % 16] = w;
        wp = wp + 1;
    endtask

    task automatic push_beats(input logic [31:0] w, input int nbeats, input int b);
        logic [31:0] s;
        logic [3:0]  f;
        s = w;
        f = 4'hF;
        for (int i = 0; i < nbeats; i++) begin
            exp_q.push_back({f >> (4 - b), s[31:28] >> (4 - b)});
            s = s << b;
        end
    endtask

    task automatic step();
        @(negedge clk);
        k++;
    endtask

    task automatic goto(input int n);
        while (k < n) step();
    endtask

    task automatic kick(input logic [1:0] m, input logic [15:0] n);
        bus.start      = 1'b1;
        bus.mode       = m;
        bus.byte_count = n;
        @(negedge clk);
        bus.start = 1'b0;
        k = 1;
    endtask

    task automatic wait_done(input int exp_cyc);
        while (!bus.done && k < 400) step();
        chk("done_cycle", k, exp_cyc);
        step();
        chk("busy_after_done", bus.busy, 0);
    endtask

    int p0;
    int saw_done;

    initial begin
        rst_n = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 2'b00; bus.byte_count = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy",  bus.busy, 0);
        chk("rst_oe",    bus.io_oe, 0);
        chk("rst_out",   bus.io_out, 0);
        chk("rst_sclk",  bus.sclk_en, 0);
        chk("rst_done",  bus.done, 0);
        chk("rst_under", bus.underrun, 0);
        chk("rst_rden",  bus.fifo_rd_en, 0);
        rst_n = 1'b0;
        @(negedge clk);

        // Quad, one full word
        p0 = pops;
        push(32'hA1B2C3D4);
        push_beats(32'hA1B2C3D4, 8, 4);
        kick(2'b10, 16'd4);
        chk("t1_rden_c1", bus.fifo_rd_en, 1);
        chk("t1_busy_c1", bus.busy, 1);
        step();
        chk("t1_sclk_c2", bus.sclk_en, 0);
        step();
        chk("t1_out_c3", bus.io_out, 4'hA);
        chk("t1_oe_c3",  bus.io_oe, 4'hF);
        goto(10);
        chk("t1_out_c10", bus.io_out, 4'h4);
        wait_done(11);
        chk("t1_pops", pops - p0, 1);

        // Single, partial word
        p0 = pops;
        push(32'h80FFFFFF);
        push_beats(32'h80FFFFFF, 8, 1);
        kick(2'b00, 16'd1);
        chk("t2_rden_c1", bus.fifo_rd_en, 1);
        goto(3);
        chk("t2_out_c3", bus.io_out, 4'h1);
        chk("t2_oe_c3",  bus.io_oe, 4'h1);
        wait_done(11);
        chk("t2_pops", pops - p0, 1);

        // Mode 11 behaves as single
        push(32'hA5000000);
        push_beats(32'hA5000000, 16, 1);
        kick(2'b11, 16'd2);
        goto(3);
        chk("t2b_oe_c3", bus.io_oe, 4'h1);
        wait_done(19);

        // Dual, multi-word with inter-word gap
        p0 = pops;
        push(32'h12345678);
        push(32'h9ABCDEF0);
        push_beats(32'h12345678, 16, 2);
        push_beats(32'h9ABCDEF0, 8, 2);
        kick(2'b01, 16'd6);
        goto(19);
        chk("t3_gap_c19", bus.sclk_en, 0);
        step();
        chk("t3_gap_c20", bus.sclk_en, 0);
        step();
        chk("t3_out_c21", bus.io_out, 4'h2);
        chk("t3_oe_c21",  bus.io_oe, 4'h3);
        wait_done(29);
        chk("t3_pops", pops - p0, 2);

        // Underrun: second word arrives after 5 stall cycles in FETCH
        p0 = pops;
        push(32'h11223344);
        push_beats(32'h11223344, 8, 4);
        push_beats(32'h55667788, 8, 4);
        kick(2'b10, 16'd8);
        goto(11);
        chk("t4_rden_empty", bus.fifo_rd_en, 0);
        goto(13);
        chk("t4_under_c13", bus.underrun, 1);
        chk("t4_sclk_c13",  bus.sclk_en, 0);
        chk("t4_busy_c13",  bus.busy, 1);
        goto(16);
        push(32'h55667788);
        #1;
        chk("t4_rden_c16", bus.fifo_rd_en, 1);
        step();
        chk("t4_sclk_c17", bus.sclk_en, 0);
        wait_done(26);
        chk("t4_under_sticky", bus.underrun, 1);
        chk("t4_pops", pops - p0, 2);

        // Zero byte count; start clears underrun
        p0 = pops;
        kick(2'b10, 16'd0);
        chk("t5_done_c1",  bus.done, 1);
        chk("t5_busy_c1",  bus.busy, 1);
        chk("t5_rden_c1",  bus.fifo_rd_en, 0);
        chk("t5_under_c1", bus.underrun, 0);
        step();
        chk("t5_busy_c2", bus.busy, 0);
        chk("t5_pops", pops - p0, 0);

        // Abort during SHIFT, with an ignored start one cycle earlier
        p0 = pops;
        push(32'hDEADBEEF);
        push_beats(32'hDEADBEEF, 8, 4);
        push_beats(32'h0F1E2D3C, 3, 4);
        kick(2'b10, 16'd8);
        goto(13);
        push(32'h0F1E2D3C);
        goto(16);
        bus.start = 1'b1; bus.mode = 2'b00; bus.byte_count = 16'd1;
        step();
        bus.start = 1'b0;
        chk("t6_under_c17", bus.underrun, 1);
        chk("t6_oe_c17",    bus.io_oe, 4'hF);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("t6_busy_c18",  bus.busy, 0);
        chk("t6_oe_c18",    bus.io_oe, 0);
        chk("t6_sclk_c18",  bus.sclk_en, 0);
        chk("t6_under_c18", bus.underrun, 1);
        saw_done = bus.done;
        repeat (4) begin
            step();
            saw_done = saw_done | bus.done;
        end
        chk("t6_no_done", saw_done, 0);
        chk("t6_pops", pops - p0, 2);

        // Synchronous reset mid-SHIFT, with underrun set beforehand
        push(32'hCAFEF00D);
        push_beats(32'hCAFEF00D, 8, 4);
        push_beats(32'h13579BDF, 3, 4);
        kick(2'b10, 16'd8);
        goto(13);
        push(32'h13579BDF);
        goto(16);
        chk("t7_under_c16", bus.underrun, 1);
        step();
        rst_n = 1'b1;
        step();
        chk("t7_busy",  bus.busy, 0);
        chk("t7_oe",    bus.io_oe, 0);
        chk("t7_out",   bus.io_out, 0);
        chk("t7_sclk",  bus.sclk_en, 0);
        chk("t7_done",  bus.done, 0);
        chk("t7_under", bus.underrun, 0);
        chk("t7_rden",  bus.fifo_rd_en, 0);
        rst_n = 1'b0;
        repeat (2) step();

        chk("sb_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/qspi_tx_shifter.md
# qspi_tx_shifter

Transmit-side data serializer of the QSPI controller: pops 32-bit write words from the TX data FIFO and shifts them onto the QSPI IO lanes in single, dual or quad mode, MSB first. It sits between the AHB-side write FIFO and the QSPI pad drivers. It is the transmit counterpart of the read-data FIFO path. It also gates the serial clock so the flash device sees edges only while valid data is on the lanes.

## Interface

- DATA_WIDTH, 32, FIFO word width; must be 32
- CNT_WIDTH, 16, width of the transfer byte counter
- clk  in  1  shifter clock (QSPI core clock)
- rst_n  in  1  synchronous, active-high reset; the name is historical and does not indicate polarity
- start  in  1  one-cycle pulse; begins a transfer; honoured only in IDLE
- abort  in  1  synchronous abort; returns the FSM to IDLE on the next edge from any state
- mode  in  2  lane mode: 00 single, 01 dual, 10 quad, 11 treated as single; latched at start
- byte_count  in  CNT_WIDTH  bytes to send; latched at start
- fifo_empty  in  1  TX FIFO empty flag
- fifo_rd_en  out  1  FIFO pop request
- fifo_rd_data  in  32  FIFO read data, registered, valid one cycle after an accepted pop
- io_out  out  4  lane data to pads
- io_oe  out  4  lane output enables
- sclk_en  out  1  serial-clock enable; high only on cycles that present a new bit group
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- underrun  out  1  sticky; set when the FSM stalls in FETCH on an empty FIFO; cleared by start or reset

## Operation

- **FSM states:** IDLE, FETCH, WAIT, SHIFT, DONE.
- **IDLE**
  - start with latched byte_count != 0 → FETCH.
  - start with byte_count == 0 → DONE; no pop occurs.
- **FETCH**
  - fifo_rd_en = !fifo_empty, combinational, for exactly the cycle the pop is accepted.
  - If the FIFO is not empty → WAIT.
  - If the FIFO is empty → stay in FETCH and set underrun.
- **WAIT:** load sr[31:0] ← fifo_rd_data, then → SHIFT.
- **Shift-cycle counter:** loaded with min(bytes_left, 4) × 8 / b, where b = 1, 2 or 4 bits per cycle.
- **SHIFT, lane mapping per cycle:**
  - single: io_out[0] = sr[31].
  - dual: io_out[1:0] = sr[31:30].
  - quad: io_out[3:0] = sr[31:28].
  - Unused io_out bits are 0.
  - After each cycle, sr shifts left by b.
- **Byte order:** byte 3 (bits 31:24) goes out first. On a partial last word, only the upper min(bytes_left, 4) bytes are sent; the lower bytes are discarded.
- **bytes_left:** decrements by 1 every 8/b SHIFT cycles and saturates at 0.
- **End of word:**
  - bytes_left > 0 → FETCH.
  - bytes_left == 0 → DONE.
- **DONE:** done = 1 for one cycle, then → IDLE.
- **Output enables:** io_oe = 0001 (single), 0011 (dual) or 1111 (quad) during SHIFT only; 0000 in all other states.
- **Clock gating:** sclk_en = 1 exactly on SHIFT cycles.
- **Ignored start:** start in any state other than IDLE has no effect on state, counters or underrun.
- **abort:**
  - Takes precedence over start and over every state transition.
  - Takes effect at the next edge: state IDLE, io_oe = 0, no done pulse.
  - underrun is preserved.
  - A pop accepted in the same cycle as abort still completes in the FIFO; its data is dropped.

## Timing

- **Reset values** (rst_n high at an edge): state IDLE, fifo_rd_en 0, io_out 0, io_oe 0, sclk_en 0, busy 0, done 0, underrun 0, sr 0, counters 0.
- **Reset mid-transfer** behaves the same as abort and also clears underrun.
- **Latency from start (cycle 0):**
  - FETCH in cycle 1, with fifo_rd_en = 1 if data is available.
  - WAIT in cycle 2.
  - First SHIFT in cycle 3.
- **Shift cycles per word:** 32 (single), 16 (dual), 8 (quad).
- **Inter-word gap:** at least 2 cycles (FETCH + WAIT) with sclk_en = 0, plus 1 cycle per underrun stall cycle.
- **Completion:** done occurs one cycle after the last SHIFT cycle; busy falls in the cycle after done.
- **byte_count = 0:** busy high for 1 cycle (DONE) and done in cycle 1.

## Test plan

- **Quad, one full word:** byte_count = 4, FIFO holds 0xA1B2C3D4, start at cycle 0.
  - fifo_rd_en in cycle 1.
  - io_out = A,1,B,2,C,3,D,4 with sclk_en = 1 in cycles 3–10.
  - io_oe = 1111 in cycles 3–10.
  - done in cycle 11.
- **Single, partial word:** byte_count = 1, FIFO holds 0x80FFFFFF.
  - io_out[0] = 1,0,0,0,0,0,0,0 over 8 SHIFT cycles; io_oe = 0001.
  - done follows; exactly one pop.
- **Dual, multi-word:** byte_count = 6, words 0x12345678 and 0x9ABCDEF0.
  - 16 SHIFT cycles, then a 2-cycle sclk_en = 0 gap, then 8 SHIFT cycles emitting 9A BC.
  - Exactly 2 pops; done follows.
- **Underrun:** quad, byte_count = 8, FIFO holds one word; push the second word 5 cycles after the FSM enters FETCH.
  - FSM holds in FETCH for 5 cycles with sclk_en = 0 and underrun = 1.
  - Transfer then completes correctly.
  - The next start clears underrun.
- **Abort, ignored start and zero count:**
  - abort in the 3rd SHIFT cycle → IDLE next cycle, io_oe = 0, no done.
  - start during SHIFT is ignored.
  - byte_count = 0 → done in cycle 1 and no fifo_rd_en.
- **Synchronous reset mid-SHIFT:** all outputs reach their reset values at the next edge.
